// File: rtl/fir_coeff_sequencer.sv
`default_nettype none
// ============================================================================
// fir_coeff_sequencer: shadow/active 5x5 FIR kernel banks, swapped one tap per
// cycle after the first vsync rise following a commit. Option: FIR_COEFF_READBACK_EN
// Revision: 1.0
// ============================================================================
module fir_coeff_sequencer #(
    parameter int COEFF_NUM  = 25,
    parameter int COEFF_W    = 16,
    parameter int FRAC_W     = 12,
    parameter int ADDR_W     = 5,
    parameter int CENTER_IDX = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [COEFF_W-1:0]           wr_data_i,
    output logic                         wr_ready_o,
    input  logic                         commit_i,
    input  logic                         vs_i,
    output logic [COEFF_NUM*COEFF_W-1:0] coeff_o,
    output logic                         pending_o,
    output logic                         swap_done_o,
`ifdef FIR_COEFF_READBACK_EN
    input  logic [ADDR_W-1:0]            rd_addr_i,
    output logic [COEFF_W-1:0]           rd_data_o,
`endif
    output logic                         overrun_o
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_PENDING = 2'd1;
    localparam logic [1:0] c_COPY    = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    localparam logic [ADDR_W:0]    c_NUM  = (ADDR_W+1)'(COEFF_NUM);
    localparam logic [ADDR_W-1:0]  c_LAST = ADDR_W'(COEFF_NUM - 1);
    localparam logic [COEFF_W-1:0] c_ONE  = COEFF_W'(1 << FRAC_W);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  idx_q;
    logic               vs_q;
    logic               commit_q;
    logic               overrun_q;
    logic [COEFF_W-1:0] shadow_q [COEFF_NUM];
    logic [COEFF_W-1:0] active_q [COEFF_NUM];

    logic w_vs_rise;
    logic w_vs_fall;
    logic w_wr_accept;
    logic w_commit_accept;

    assign w_vs_rise       = vs_i & ~vs_q;
    assign w_vs_fall       = vs_q & ~vs_i;
    assign w_wr_accept     = wr_en_i & wr_ready_o & ({1'b0, wr_addr_i} < c_NUM);
    assign w_commit_accept = commit_i & (state_q != c_PENDING);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:    if (commit_i) state_d = c_PENDING;
            c_PENDING: if (w_vs_rise) state_d = c_COPY;
            c_COPY:    if (idx_q == c_LAST) state_d = c_DONE;
            c_DONE:    state_d = (commit_q | commit_i) ? c_PENDING : c_IDLE;
            default:   state_d = c_IDLE;
        endcase
    end

    always_comb begin
        wr_ready_o  = (state_q != c_COPY);
        pending_o   = (state_q == c_PENDING) || (state_q == c_COPY) ||
                      ((state_q == c_DONE) && commit_q);
        swap_done_o = (state_q == c_DONE);
    end

    // A commit seen during COPY/DONE is remembered and re-arms the swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q      <= 1'b1;
            idx_q     <= '0;
            commit_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            vs_q <= vs_i;
            if ((state_q == c_PENDING) && w_vs_rise) begin
                idx_q <= '0;
            end else if (state_q == c_COPY) begin
                idx_q <= idx_q + ADDR_W'(1);
            end
            if (state_q == c_DONE) begin
                commit_q <= 1'b0;
            end else if ((state_q == c_COPY) && commit_i) begin
                commit_q <= 1'b1;
            end
            if ((state_q == c_COPY) && w_vs_fall) begin
                overrun_q <= 1'b1;
            end else if (w_commit_accept) begin
                overrun_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < COEFF_NUM; k++) begin
                shadow_q[k] <= (k == CENTER_IDX) ? c_ONE : '0;
                active_q[k] <= (k == CENTER_IDX) ? c_ONE : '0;
            end
        end else begin
            if (w_wr_accept) begin
                shadow_q[wr_addr_i] <= wr_data_i;
            end
            if (state_q == c_COPY) begin
                active_q[idx_q] <= shadow_q[idx_q];
            end
        end
    end

    assign overrun_o = overrun_q;

    for (genvar k = 0; k < COEFF_NUM; k++) begin : g_pack
        assign coeff_o[k*COEFF_W +: COEFF_W] = active_q[k];
    end

`ifdef FIR_COEFF_READBACK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= ({1'b0, rd_addr_i} < c_NUM) ? active_q[rd_addr_i] : '0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_sequencer.sv
`default_nettype none
// Bench for fir_coeff_sequencer: event-level bank model plus directed scenarios.
module tb_fir_coeff_sequencer;
    localparam int N  = 25;
    localparam int W  = 16;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0;
    logic commit = 1'b0;
    logic vs = 1'b1;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic wr_ready, pending, swap_done, overrun;
    logic [N*W-1:0] coeff;
`ifdef FIR_COEFF_READBACK_EN
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_data;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fir_coeff_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .wr_ready_o (wr_ready),
        .commit_i   (commit),
        .vs_i       (vs),
        .coeff_o    (coeff),
        .pending_o  (pending),
        .swap_done_o(swap_done),
`ifdef FIR_COEFF_READBACK_EN
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
`endif
        .overrun_o  (overrun)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: copy_off = -1 not copying, 0..N-1 copying tap copy_off, N = done cycle.
    logic [W-1:0] sh_m [N];
    logic [W-1:0] ac_m [N];
    int copy_off = -1;
    bit pend_m, again_m, ovr_m, vsp_m;
    bit m_copying, m_done, m_rise, m_fall;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                sh_m[k] = (k == 12) ? 16'd4096 : 16'd0;
                ac_m[k] = (k == 12) ? 16'd4096 : 16'd0;
            end
            copy_off = -1; pend_m = 0; again_m = 0; ovr_m = 0; vsp_m = 1;
        end else begin
            m_copying = (copy_off >= 0) && (copy_off < N);
            m_done    = (copy_off == N);
            m_rise    = vs && !vsp_m;
            m_fall    = !vs && vsp_m;
            vsp_m     = vs;
            if (wr_en && !m_copying && int'(wr_addr) < N) sh_m[wr_addr] = wr_data;
            if (commit && !(pend_m && copy_off < 0)) ovr_m = 0;
            if (m_copying && m_fall) ovr_m = 1;
            if (m_copying) begin
                ac_m[copy_off] = sh_m[copy_off];
                if (commit) again_m = 1;
                copy_off++;
            end else if (m_done) begin
                pend_m = again_m || commit;
                again_m = 0;
                copy_off = -1;
            end else if (pend_m) begin
                if (m_rise) copy_off = 0;
            end else if (commit) begin
                pend_m = 1;
            end
        end
    end

    logic [N*W-1:0] exp_coeff;
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) exp_coeff[k*W +: W] = ac_m[k];
            checks++;
            if (coeff !== exp_coeff) begin
                errors++;
                for (int k = 0; k < N; k++)
                    if (coeff[k*W +: W] !== exp_coeff[k*W +: W])
                        $display("FAIL coeff tap%0d: got %0h expected %0h",
                                 k, coeff[k*W +: W], exp_coeff[k*W +: W]);
            end
            chk("m_wr_ready", wr_ready, !((copy_off >= 0) && (copy_off < N)));
            chk("m_swap_done", swap_done, copy_off == N);
            chk("m_pending", pending, (copy_off == N) ? again_m : pend_m);
            chk("m_overrun", overrun, ovr_m);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_commit();
        commit = 1'b1; tick(); commit = 1'b0;
    endtask

    task automatic vs_edge();
        vs = 1'b0; tick(); vs = 1'b1;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (!swap_done && t < 60) begin
            tick();
            t++;
        end
        if (!swap_done) chk({nm, "_timeout"}, swap_done, 1'b1);
    endtask

    initial begin
        int t;
        int z;
        rst = 1'b1; vs = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("rst_tap12", coeff[12*W +: W], 64'd4096);
        chk("rst_tap0", coeff[0 +: W], 64'd0);
        chk("rst_ready", wr_ready, 1'b1);
        chk("rst_pending", pending, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        tick(5);
        chk("idle_vs_high", pending, 1'b0);

        // shadow[0] = -256, commit, then one vsync rise
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'hFF00; commit = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        tick(4);
        chk("pend_no_rise", pending, 1'b1);
        chk("pend_tap0_old", coeff[0 +: W], 64'd0);
        vs_edge();
        tick();
        chk("copy_tap0_n1", coeff[0 +: W], 64'd0);
        tick();
        chk("copy_tap0_n2", coeff[0 +: W], 64'hFF00);
        t = 2;
        while (!swap_done && t < 60) begin
            tick();
            t++;
        end
        chk("done_latency", t, 64'd26);
        chk("done_pending_low", pending, 1'b0);
        tick();
        chk("done_one_cycle", swap_done, 1'b0);

        // write held across COPY is stalled and lands after DONE
        pulse_commit();
        vs_edge();
        tick();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'd77;
        z = 0;
        for (int i = 0; i < 30; i++) begin
            if (!wr_ready) z++;
            tick();
        end
        wr_en = 1'b0;
        chk("copy_ready_low_cycles", z, 64'd25);
        chk("tap3_not_swapped", coeff[3*W +: W], 64'd0);

        // commit during COPY at idx 10 re-arms the swap
        pulse_commit();
        vs_edge();
        tick(11);
        pulse_commit();
        wait_done("swap1");
        chk("rearm_pending_done", pending, 1'b1);
        tick();
        chk("rearm_pending_after", pending, 1'b1);
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 16'd123;
        tick();
        wr_en = 1'b0;
        vs_edge();
        wait_done("swap2");
        chk("swap2_pending_low", pending, 1'b0);
        tick();
        chk("swap2_tap2", coeff[2*W +: W], 64'd123);
        chk("swap2_tap3", coeff[3*W +: W], 64'd77);

        // vsync falls mid-copy
        pulse_commit();
        vs_edge();
        tick(6);
        vs = 1'b0;
        tick();
        chk("overrun_set", overrun, 1'b1);
        wait_done("overrun_swap");
        chk("overrun_still_set", overrun, 1'b1);
        tick();
        pulse_commit();
        chk("overrun_cleared", overrun, 1'b0);

        // out-of-range write is ignored
        wr_en = 1'b1; wr_addr = 5'd30; wr_data = 16'd999;
        chk("oor_ready", wr_ready, 1'b1);
        tick();
        wr_en = 1'b0;
        vs = 1'b1;
        wait_done("oor_swap");
        tick(2);
        chk("oor_tap12", coeff[12*W +: W], 64'd4096);
`ifdef FIR_COEFF_READBACK_EN
        rd_addr = 5'd12;
        tick();
        chk("rd_tap12", rd_data, 64'd4096);
        rd_addr = 5'd30;
        tick();
        chk("rd_oor", rd_data, 64'd0);
`endif
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
